// File: rtl/stream_qos_pkg.sv
// Shared types for the QoS stream router: route FSM states, counter default,
// and the control flags carried with every beat through the hold register.
package stream_qos_pkg;

  typedef enum logic [1:0] {
    ST_HEAD,
    ST_BODY,
    ST_DROP
  } route_state_t;

  localparam int DROP_CNT_WIDTH_DEFAULT = 8;

  // Width-independent part of the hold-register payload; the top module wraps
  // it with its parameterised data/dest/qos fields.
  typedef struct packed {
    logic last;
    logic bad;
  } hold_flags_t;

  function automatic logic id_out_of_range(input int id, input int count);
    return id >= count;
  endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// One-entry valid/ready pipeline register. It accepts a new word in the same
// cycle the held one leaves, and refuses input while reset is asserted.
module stream_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  assign in_ready = !rst && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_router_w_qos.sv
// 1:N packet router: steers whole packets to stream[id] with qos locked from
// the head beat; packets with an out-of-range id are swallowed and counted.
module stream_router_w_qos
  import stream_qos_pkg::*;
#(
  parameter int T_DATA_WIDTH   = 4,
  parameter int T_QOS__WIDTH   = 2,
  parameter int STREAM_COUNT   = 2,
  parameter int T_ID___WIDTH   = $clog2(STREAM_COUNT),
  parameter int DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEFAULT
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [T_DATA_WIDTH-1:0]                    s_data_in,
  input  logic [T_QOS__WIDTH-1:0]                    s_qos_in,
  input  logic [T_ID___WIDTH-1:0]                    s_id_in,
  input  logic                                       s_last_in,
  input  logic                                       s_valid_in,
  output logic                                       s_ready_out,
  output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]  m_data_out,
  output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0]  m_qos_out,
  output logic [STREAM_COUNT-1:0]                    m_last_out,
  output logic [STREAM_COUNT-1:0]                    m_valid_out,
  input  logic [STREAM_COUNT-1:0]                    m_ready_in,
  output logic                                       err_bad_id_out,
  output logic [DROP_CNT_WIDTH-1:0]                  drop_count_out
);

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic [T_ID___WIDTH-1:0] dest;
    logic [T_QOS__WIDTH-1:0] qos;
    hold_flags_t             flags;
  } hold_payload_t;

  route_state_t            state;
  route_state_t            next_state;
  logic [T_ID___WIDTH-1:0] ctx_dest;
  logic [T_QOS__WIDTH-1:0] ctx_qos;
  hold_payload_t           push_payload;
  hold_payload_t           hold_payload;
  logic                    hold_valid;
  logic                    accept;
  logic                    head_bad;
  logic                    sel_ready;
  logic                    pop;

  assign head_bad = id_out_of_range(int'(s_id_in), STREAM_COUNT);
  assign accept   = s_valid_in && s_ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HEAD;
    end else if (accept) begin
      state <= next_state;
    end
  end

  // Packet context is latched from the head so body beats ignore s_id/s_qos.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_dest <= '0;
      ctx_qos  <= '0;
    end else if (accept && state == ST_HEAD) begin
      ctx_dest <= s_id_in;
      ctx_qos  <= s_qos_in;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_HEAD: begin
        if (!s_last_in) begin
          next_state = head_bad ? ST_DROP : ST_BODY;
        end
      end
      ST_BODY, ST_DROP: begin
        if (s_last_in) begin
          next_state = ST_HEAD;
        end
      end
      default: next_state = ST_HEAD;
    endcase
  end

  always_comb begin
    push_payload.data       = s_data_in;
    push_payload.flags.last = s_last_in;
    push_payload.dest       = ctx_dest;
    push_payload.qos        = ctx_qos;
    push_payload.flags.bad  = 1'b0;
    err_bad_id_out          = 1'b0;
    case (state)
      ST_HEAD: begin
        push_payload.dest      = s_id_in;
        push_payload.qos       = s_qos_in;
        push_payload.flags.bad = head_bad;
        err_bad_id_out         = accept && head_bad;
      end
      ST_DROP: push_payload.flags.bad = 1'b1;
      default: ;
    endcase
  end

  stream_hold_reg #(
    .WIDTH ($bits(hold_payload_t))
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_data   (push_payload),
    .in_valid  (s_valid_in),
    .in_ready  (s_ready_out),
    .out_data  (hold_payload),
    .out_valid (hold_valid),
    .out_ready (pop)
  );

  // Bad beats never wait for a consumer; good beats wait only on their own stream.
  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      if (hold_payload.dest == T_ID___WIDTH'(i)) begin
        sel_ready = m_ready_in[i];
      end
    end
  end

  assign pop = hold_valid && (hold_payload.flags.bad || sel_ready);

  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      m_valid_out[i] = hold_valid && !hold_payload.flags.bad &&
                       (hold_payload.dest == T_ID___WIDTH'(i));
      m_data_out[i]  = m_valid_out[i] ? hold_payload.data : '0;
      m_qos_out[i]   = m_valid_out[i] ? hold_payload.qos  : '0;
      m_last_out[i]  = m_valid_out[i] && hold_payload.flags.last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_out <= '0;
    end else if (pop && hold_payload.flags.bad && hold_payload.flags.last &&
                 drop_count_out != '1) begin
      drop_count_out <= drop_count_out + DROP_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_stream_router_w_qos.sv
// Self-checking bench for stream_router_w_qos with 3 streams: directed scenarios
// plus randomized packets checked against a packet-level reference model.
module tb_stream_router_w_qos;

  localparam int SC  = 3;
  localparam int IDW = 2;
  localparam int DW  = 4;
  localparam int QW  = 2;
  localparam int CW  = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DW-1:0]          s_data;
  logic [QW-1:0]          s_qos;
  logic [IDW-1:0]         s_id;
  logic                   s_last;
  logic                   s_valid;
  logic                   s_ready;
  logic [SC-1:0][DW-1:0]  m_data;
  logic [SC-1:0][QW-1:0]  m_qos;
  logic [SC-1:0]          m_last;
  logic [SC-1:0]          m_valid;
  logic [SC-1:0]          m_ready;
  logic                   err;
  logic [CW-1:0]          drop_count;

  always #5 clk = ~clk;

  stream_router_w_qos #(
    .T_DATA_WIDTH   (DW),
    .T_QOS__WIDTH   (QW),
    .STREAM_COUNT   (SC),
    .T_ID___WIDTH   (IDW),
    .DROP_CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_data_in      (s_data),
    .s_qos_in       (s_qos),
    .s_id_in        (s_id),
    .s_last_in      (s_last),
    .s_valid_in     (s_valid),
    .s_ready_out    (s_ready),
    .m_data_out     (m_data),
    .m_qos_out      (m_qos),
    .m_last_out     (m_last),
    .m_valid_out    (m_valid),
    .m_ready_in     (m_ready),
    .err_bad_id_out (err),
    .drop_count_out (drop_count)
  );

  typedef struct packed {
    logic [1:0]    stream;
    logic [DW-1:0] data;
    logic [QW-1:0] qos;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_cyc[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int err_seen = 0;
  int multi_valid_err = 0;
  int zero_err = 0;
  int ready_low = 0;
  int stall_cycles = 0;
  int valid_cnt[SC];

  bit         rand_ready = 0;
  bit         pkt_active = 0;
  logic [1:0] pkt_id;
  logic [1:0] pkt_qos;
  bit         pkt_bad;
  int         exp_err = 0;
  int         exp_drops = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Observes every completed output handshake and records protocol invariants.
  initial begin
    for (int i = 0; i < SC; i++) valid_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if ($countones(m_valid) > 1) multi_valid_err++;
        if (err) err_seen++;
        if (!s_ready) ready_low++;
        for (int i = 0; i < SC; i++) begin
          if (m_valid[i]) begin
            valid_cnt[i]++;
            if (m_ready[i]) begin
              beat_t b;
              b.stream = 2'(i);
              b.data   = m_data[i];
              b.qos    = m_qos[i];
              b.last   = m_last[i];
              obs_q.push_back(b);
              obs_cyc.push_back(cyc);
            end
          end else if (m_data[i] != '0 || m_qos[i] != '0 || m_last[i]) begin
            zero_err++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = 3'($urandom);
  endtask

  // Packet-level reference: the head decides stream, qos and drop for the packet.
  task automatic model_accept(input logic [DW-1:0] d, input logic [QW-1:0] q,
                              input logic [IDW-1:0] id, input logic l);
    beat_t b;
    if (!pkt_active) begin
      pkt_id  = id;
      pkt_qos = q;
      pkt_bad = (int'(id) >= SC);
      if (pkt_bad) exp_err++;
    end
    if (!pkt_bad) begin
      b.stream = pkt_id;
      b.data   = d;
      b.qos    = pkt_qos;
      b.last   = l;
      exp_q.push_back(b);
    end
    if (l && pkt_bad && exp_drops < (1 << CW) - 1) exp_drops++;
    pkt_active = !l;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [QW-1:0] q,
                           input logic [IDW-1:0] id, input logic l);
    bit done = 0;
    s_data  = d;
    s_qos   = q;
    s_id    = id;
    s_last  = l;
    s_valid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (s_ready) begin
        done = 1;
        model_accept(d, q, id, l);
      end else begin
        stall_cycles++;
      end
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL send_timeout id=%0d data=%h not accepted, required accept within 64 cycles", id, d);
    end
  endtask

  task automatic drain(input int n);
    rand_ready = 0;
    m_ready = '1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = '1;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_low got=%b want=0", s_ready); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 3'b000) begin failures++; $display("[TB] FAIL reset_valid got=%b want=000", m_valid); end
    checks++;
    if (m_data !== '0 || m_qos !== '0 || m_last !== '0) begin
      failures++; $display("[TB] FAIL reset_outputs data=%h qos=%h last=%b want zeros", m_data, m_qos, m_last);
    end
    checks++;
    if (drop_count !== '0 || err !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_counters drop=%0d err=%b want 0/0", drop_count, err);
    end
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_after got=%b want=1", s_ready); end
    tick();
    pkt_active = 0;
    exp_drops = 0;
  endtask

  task automatic test_single_beat();
    clear_queues();
    m_ready = '1;
    send_beat(4'hA, 2'd1, 2'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (m_valid !== 3'b100) begin failures++; $display("[TB] FAIL single_valid got=%b want=100", m_valid); end
    checks++;
    if (m_data[2] !== 4'hA || m_qos[2] !== 2'd1 || m_last[2] !== 1'b1) begin
      failures++; $display("[TB] FAIL single_payload data=%h qos=%0d last=%b want A/1/1", m_data[2], m_qos[2], m_last[2]);
    end
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_ready got=%b want=1", s_ready); end
    drain(3);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL single_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin failures++; $display("[TB] FAIL single_beat%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_packet_lock();
    int v0 = valid_cnt[0];
    int v2 = valid_cnt[2];
    int on_one = 0;
    clear_queues();
    m_ready = '1;
    send_beat(4'h1, 2'd3, 2'd1, 1'b0);
    send_beat(4'h2, 2'd0, 2'd0, 1'b0);
    send_beat(4'h3, 2'd0, 2'd0, 1'b1);
    drain(4);
    foreach (obs_q[k]) if (obs_q[k].stream == 2'd1 && obs_q[k].qos == 2'd3) on_one++;
    checks++;
    if (on_one !== 3) begin failures++; $display("[TB] FAIL lock_stream1_beats got=%0d want=3", on_one); end
    checks++;
    if (valid_cnt[0] - v0 !== 0 || valid_cnt[2] - v2 !== 0) begin
      failures++; $display("[TB] FAIL lock_other_valid s0=%0d s2=%0d want 0/0", valid_cnt[0] - v0, valid_cnt[2] - v2);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL lock_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin failures++; $display("[TB] FAIL lock_beat%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    clear_queues();
    m_ready = 3'b110;
    send_beat(4'h5, 2'd2, 2'd0, 1'b0);
    s_data  = 4'hC;
    s_qos   = 2'd1;
    s_id    = 2'd0;
    s_last  = 1'b1;
    s_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 3'b001 || m_data[0] !== 4'h5) begin
        failures++;
        $display("[TB] FAIL bp_hold cyc%0d ready=%b valid=%b data=%h want 0/001/5", n, s_ready, m_valid, m_data[0]);
      end
      tick();
    end
    m_ready = '1;
    send_beat(4'hC, 2'd1, 2'd0, 1'b1);
    drain(3);
    checks++;
    if (obs_q.size() !== 2) begin failures++; $display("[TB] FAIL bp_count got=%0d want=2", obs_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin failures++; $display("[TB] FAIL bp_beat%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_bad_id();
    int e0 = err_seen;
    int x0 = exp_err;
    int vs = valid_cnt[0] + valid_cnt[1] + valid_cnt[2];
    clear_queues();
    m_ready = '1;
    checks++;
    if (drop_count !== 8'd0) begin failures++; $display("[TB] FAIL bad_drop_before got=%0d want=0", drop_count); end
    send_beat(4'h3, 2'd1, 2'd3, 1'b0);
    send_beat(4'h7, 2'd0, 2'd1, 1'b1);
    drain(2);
    checks++;
    if (drop_count !== CW'(exp_drops) || exp_drops !== 1) begin
      failures++; $display("[TB] FAIL bad_drop_after got=%0d want=1", drop_count);
    end
    send_beat(4'h9, 2'd2, 2'd0, 1'b1);
    drain(3);
    checks++;
    if (err_seen - e0 !== exp_err - x0 || err_seen - e0 !== 1) begin
      failures++; $display("[TB] FAIL bad_err_pulses got=%0d want=1", err_seen - e0);
    end
    checks++;
    if (valid_cnt[0] + valid_cnt[1] + valid_cnt[2] - vs !== 1) begin
      failures++; $display("[TB] FAIL bad_valid_cycles got=%0d want=1", valid_cnt[0] + valid_cnt[1] + valid_cnt[2] - vs);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL bad_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin failures++; $display("[TB] FAIL bad_beat%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int rl = ready_low;
    int sc = stall_cycles;
    logic [1:0] ids [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    clear_queues();
    m_ready = '1;
    for (int i = 0; i < 4; i++) send_beat(DW'(i + 1), QW'(i), ids[i], 1'b1);
    drain(3);
    checks++;
    if (stall_cycles - sc !== 0 || ready_low - rl !== 0) begin
      failures++; $display("[TB] FAIL b2b_stalls stalls=%0d ready_low=%0d want 0/0", stall_cycles - sc, ready_low - rl);
    end
    for (int k = 1; k < obs_cyc.size(); k++) begin
      checks++;
      if (obs_cyc[k] - obs_cyc[k-1] !== 1) begin
        failures++; $display("[TB] FAIL b2b_gap beat%0d gap=%0d want=1", k, obs_cyc[k] - obs_cyc[k-1]);
      end
    end
    checks++;
    if (obs_q.size() !== 4) begin failures++; $display("[TB] FAIL b2b_count got=%0d want=4", obs_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin failures++; $display("[TB] FAIL b2b_beat%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_queues();
    m_ready = 3'b011;
    send_beat(4'h6, 2'd3, 2'd2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL rmid_ready got=%b want=0", s_ready); end
    tick();
    rst = 1'b0;
    pkt_active = 0;
    exp_drops = 0;
    clear_queues();
    @(negedge clk);
    checks++;
    if (m_valid !== 3'b000 || drop_count !== 8'd0) begin
      failures++; $display("[TB] FAIL rmid_clear valid=%b drop=%0d want 000/0", m_valid, drop_count);
    end
    tick();
    m_ready = '1;
    send_beat(4'h3, 2'd1, 2'd0, 1'b1);
    drain(3);
    checks++;
    if (obs_q.size() !== 1) begin failures++; $display("[TB] FAIL rmid_count got=%0d want=1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0].stream !== 2'd0 || obs_q[0] !== exp_q[0]) begin
        failures++; $display("[TB] FAIL rmid_beat got=%h want=%h", obs_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_random();
    clear_queues();
    rand_ready = 1;
    for (int p = 0; p < 40; p++) begin
      logic [1:0] hid = 2'($urandom_range(0, 3));
      int len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        logic [1:0] bid = (b == 0) ? hid : 2'($urandom);
        send_beat(4'($urandom), 2'($urandom), bid, b == len - 1);
      end
    end
    drain(6);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin failures++; $display("[TB] FAIL rand_beat%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
    end
    checks++;
    if (drop_count !== CW'(exp_drops)) begin failures++; $display("[TB] FAIL rand_drops got=%0d want=%0d", drop_count, exp_drops); end
    checks++;
    if (err_seen !== exp_err) begin failures++; $display("[TB] FAIL rand_err_total got=%0d want=%0d", err_seen, exp_err); end
    checks++;
    if (multi_valid_err !== 0 || zero_err !== 0) begin
      failures++; $display("[TB] FAIL invariants multi_valid=%0d nonzero_idle=%0d want 0/0", multi_valid_err, zero_err);
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_data  = '0;
    s_qos   = '0;
    s_id    = '0;
    s_last  = 1'b0;
    s_valid = 1'b0;
    m_ready = '1;
    test_reset();
    test_single_beat();
    test_packet_lock();
    test_backpressure();
    test_bad_id();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
